// File: rtl/pkt_comm_pkg.sv
// pkt_comm_pkg: shared character/word sizing for the pkt_comm candidate path.
`ifndef MSB
`define MSB(x) ($clog2((x)+1)-1)
`endif

package pkt_comm_pkg;
  localparam int CHAR_BITS_DEF = 7;
  localparam int RANGES_MAX_DEF = 8;
  localparam int WORDS_INSERT_MAX_DEF = 4;
  typedef enum logic {IDLE, EMIT} state_e;
endpackage

// File: rtl/word_insert_shift.sv
// word_insert_shift: places one insert word at its position inside a range candidate, shifting range chars up.
module word_insert_shift
  import pkt_comm_pkg::*;
#(
  parameter int CHAR_BITS = CHAR_BITS_DEF,
  parameter int RANGES_MAX = RANGES_MAX_DEF,
  parameter int WORD_MAX_LEN = RANGES_MAX,
  parameter int LEN_W = 4,
  parameter int POS_W = 3
) (
  input  logic [WORD_MAX_LEN*CHAR_BITS-1:0] word_i,
  input  logic [LEN_W-1:0]                  len_i,
  input  logic [POS_W-1:0]                  pos_i,
  input  logic [RANGES_MAX*CHAR_BITS-1:0]   range_i,
  output logic [WORD_MAX_LEN*CHAR_BITS-1:0] dout_o
);
  localparam int SW = `MSB(2*WORD_MAX_LEN)+1;
  localparam int N = 2**SW;
  // zero-padded char arrays so every index the sums can reach is in range
  logic [CHAR_BITS-1:0] rng [N];
  logic [CHAR_BITS-1:0] wrd [N];
  logic [SW-1:0] p, pe;
  assign p = SW'(pos_i);
  assign pe = p + SW'(len_i);
  for (genvar k = 0; k < N; k++) begin : g_pad
    if (k < RANGES_MAX) begin : g_r
      assign rng[k] = range_i[k*CHAR_BITS +: CHAR_BITS];
    end else begin : g_rz
      assign rng[k] = '0;
    end
    if (k < WORD_MAX_LEN) begin : g_w
      assign wrd[k] = word_i[k*CHAR_BITS +: CHAR_BITS];
    end else begin : g_wz
      assign wrd[k] = '0;
    end
  end
  for (genvar i = 0; i < WORD_MAX_LEN; i++) begin : g_c
    logic [SW-1:0] ii;
    assign ii = SW'(i);
    assign dout_o[i*CHAR_BITS +: CHAR_BITS] = ii < p  ? rng[ii] :
                                              ii < pe ? wrd[ii - p] : rng[ii - SW'(len_i)];
  end
endmodule

// File: rtl/word_insert_multi.sv
// word_insert_multi: emits one candidate per configured insert word for every generator candidate.
module word_insert_multi
  import pkt_comm_pkg::*;
#(
  parameter int CHAR_BITS = CHAR_BITS_DEF,
  parameter int RANGES_MAX = RANGES_MAX_DEF,
  parameter int WORD_MAX_LEN = RANGES_MAX,
  parameter int WORDS_INSERT_MAX = WORDS_INSERT_MAX_DEF,
  localparam int AW = `MSB(WORDS_INSERT_MAX-1)+1,
  localparam int LW = `MSB(WORD_MAX_LEN)+1,
  localparam int PW = `MSB(WORD_MAX_LEN-1)+1,
  localparam int CW = `MSB(WORDS_INSERT_MAX)+1,
  localparam int DW = WORD_MAX_LEN*CHAR_BITS,
  localparam int RW = RANGES_MAX*CHAR_BITS
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          cfg_wr_en,
  input  logic [AW-1:0] cfg_wr_addr,
  input  logic [DW-1:0] cfg_word,
  input  logic [LW-1:0] cfg_len,
  input  logic [PW-1:0] cfg_pos,
  input  logic          cfg_count_en,
  input  logic [CW-1:0] cfg_count,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] range_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] out_idx,
  output logic          out_last
);
  localparam int NE = 2**AW;
  state_e        state_q;
  logic [DW-1:0] word_q [NE];
  logic [LW-1:0] len_q [NE];
  logic [PW-1:0] pos_q [NE];
  logic [CW-1:0] count_q, cnt_w, cnt_eff;
  logic [RW-1:0] range_q, range_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] dout_q, dout_d, word_d;
  logic [LW-1:0] len_w, len_d;
  logic [PW-1:0] pos_d;
  logic          valid_q, last_q, last_d, accept, hs, load, wr_ok, cnt_ok, hit;
  assign busy = state_q == EMIT;
  assign hs = valid_q & out_ready;
  assign in_ready = reset_n & (!busy | (hs & last_q));
  assign accept = in_valid & in_ready;
  assign load = accept | (hs & !last_q);
  assign wr_ok = cfg_wr_en & !busy;
  assign cnt_ok = cfg_count_en & !busy;
  assign out_valid = valid_q;
  assign dout = dout_q;
  assign out_idx = idx_q;
  assign out_last = last_q;
  // a table write landing with an accept is forwarded so the new input sees it
  always_comb begin
    len_w = cfg_len > LW'(WORD_MAX_LEN) ? LW'(WORD_MAX_LEN) : cfg_len;
    cnt_w = cfg_count > CW'(WORDS_INSERT_MAX) ? CW'(WORDS_INSERT_MAX) : cfg_count;
    idx_d = accept ? '0 : idx_q + 1'b1;
    range_d = accept ? range_dout : range_q;
    hit = wr_ok & (cfg_wr_addr == idx_d);
    word_d = hit ? cfg_word : word_q[idx_d];
    len_d = hit ? len_w : len_q[idx_d];
    pos_d = hit ? cfg_pos : pos_q[idx_d];
    cnt_eff = cnt_ok ? cnt_w : count_q;
    last_d = CW'(idx_d) + 1'b1 >= cnt_eff;
  end
  word_insert_shift #(
    .CHAR_BITS(CHAR_BITS), .RANGES_MAX(RANGES_MAX), .WORD_MAX_LEN(WORD_MAX_LEN),
    .LEN_W(LW), .POS_W(PW)
  ) u_shift (
    .word_i(word_d), .len_i(len_d), .pos_i(pos_d), .range_i(range_d), .dout_o(dout_d)
  );
  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      idx_q <= '0;
      dout_q <= '0;
      range_q <= '0;
    end else if (load) begin
      state_q <= EMIT;
      valid_q <= 1'b1;
      range_q <= range_d;
      idx_q <= idx_d;
      dout_q <= dout_d;
      last_q <= last_d;
    end else if (hs) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end
  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) begin
      count_q <= '0;
      for (int k = 0; k < NE; k++) begin
        word_q[k] <= '0;
        len_q[k] <= '0;
        pos_q[k] <= '0;
      end
    end else begin
      if (wr_ok) begin
        word_q[cfg_wr_addr] <= cfg_word;
        len_q[cfg_wr_addr] <= len_w;
        pos_q[cfg_wr_addr] <= cfg_pos;
      end
      if (cnt_ok) count_q <= cnt_w;
    end
endmodule

// File: tb/tb_word_insert_multi.sv
// tb_word_insert_multi: vector table plus scoreboard for the multi-word inserter.
module tb_word_insert_multi;
  logic        CLK = 1'b0, reset_n = 1'b1;
  logic        cfg_wr_en = 1'b0, cfg_count_en = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0]  cfg_wr_addr = '0;
  logic [55:0] cfg_word = '0, range_dout = '0;
  logic [3:0]  cfg_len = '0;
  logic [2:0]  cfg_pos = '0, cfg_count = '0;
  logic        busy, in_ready, out_valid, out_last;
  logic [55:0] dout;
  logic [1:0]  out_idx;
  int n_chk = 0, n_fail = 0;

  typedef struct packed { logic [55:0] d; logic [1:0] idx; logic last; } exp_t;
  exp_t sbq[$];

  typedef struct packed {
    logic [2:0]       cnt;
    logic [2:0][63:0] w;
    logic [2:0][3:0]  l;
    logic [2:0][2:0]  p;
    logic [63:0]      rin;
    logic [2:0][63:0] e;
  } vec_t;
  vec_t vt[7];

  word_insert_multi dut (
    .CLK(CLK), .reset_n(reset_n), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_word(cfg_word), .cfg_len(cfg_len), .cfg_pos(cfg_pos), .cfg_count_en(cfg_count_en),
    .cfg_count(cfg_count), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .range_dout(range_dout), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 CLK = ~CLK;

  // right-aligned ASCII literal -> 7-bit chars with char0 at the LSBs
  function automatic logic [55:0] pk(input logic [63:0] s);
    int n = 0;
    logic [55:0] r = '0;
    for (int b = 0; b < 8; b++) if (s[b*8 +: 8] != 8'd0) n = b + 1;
    for (int i = 0; i < n; i++) r[i*7 +: 7] = s[(n-1-i)*8 +: 7];
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [63:0] w, input logic [3:0] l, input logic [2:0] p);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_word = pk(w); cfg_len = l; cfg_pos = p;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic set_count(input logic [2:0] c);
    cfg_count_en = 1'b1; cfg_count = c;
    tick();
    cfg_count_en = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0][55:0] e, input int n);
    for (int k = 0; k < n; k++) sbq.push_back('{d: e[k], idx: 2'(k), last: k == n - 1});
  endtask

  task automatic send(input logic [55:0] r, input logic [2:0][55:0] e, input int n);
    push_exp(e, n);
    in_valid = 1'b1; range_dout = r;
    for (int t = 0; t < 100 && !in_ready; t++) tick();
    check("send_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("latency_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sbq.size() != 0; t++) tick();
    check("drain", 64'(sbq.size()), 64'd0);
    tick();
  endtask

  always @(negedge CLK)
    if (reset_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_out: got dout %h idx %0d, expected no output", dout, out_idx);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out_dout", 64'(dout), 64'(e.d));
        check("out_idx", 64'(out_idx), 64'(e.idx));
        check("out_last", 64'(out_last), 64'(e.last));
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0][55:0] ex, ex2;
    logic [55:0] held;
    for (int i = 0; i < 7; i++) vt[i] = '0;
    vt[0].rin = "abcdefgh"; vt[0].e[0] = "abcdefgh";
    vt[1].cnt = 1; vt[1].w[0] = "XY"; vt[1].l[0] = 2; vt[1].p[0] = 3;
    vt[1].rin = "abcdefgh"; vt[1].e[0] = "abcXYdef";
    vt[2].cnt = 3; vt[2].w[0] = "Z"; vt[2].l[0] = 1; vt[2].w[1] = "QQ"; vt[2].l[1] = 2; vt[2].p[1] = 7;
    vt[2].rin = "abcdefgh"; vt[2].e[0] = "Zabcdefg"; vt[2].e[1] = "abcdefgQ"; vt[2].e[2] = "abcdefgh";
    vt[3].cnt = 2; vt[3].w[0] = "ABCDEFGH"; vt[3].l[0] = 9; vt[3].p[1] = 7;
    vt[3].rin = "abcdefgh"; vt[3].e[0] = "ABCDEFGH"; vt[3].e[1] = "abcdefgh";
    vt[4].cnt = 1; vt[4].w[0] = "hi"; vt[4].l[0] = 2; vt[4].p[0] = 6;
    vt[4].rin = "01234567"; vt[4].e[0] = "012345hi";
    vt[5].cnt = 1; vt[5].w[0] = "MNO"; vt[5].l[0] = 3;
    vt[5].rin = "pqrstuvw"; vt[5].e[0] = "MNOpqrst";
    vt[6].cnt = 1; vt[6].w[0] = "UVWXY"; vt[6].l[0] = 5; vt[6].p[0] = 5;
    vt[6].rin = "abcdefgh"; vt[6].e[0] = "abcdeUVW";

    #2 reset_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    @(negedge CLK) reset_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 3; k++) write_entry(2'(k), vt[i].w[k], vt[i].l[k], vt[i].p[k]);
      set_count(vt[i].cnt);
      for (int k = 0; k < 3; k++) ex[k] = pk(vt[i].e[k]);
      send(pk(vt[i].rin), ex, vt[i].cnt == 0 ? 1 : int'(vt[i].cnt));
      drain();
    end

    // stall mid-sequence with a second input waiting
    write_entry(0, "Z", 1, 0); write_entry(1, "QQ", 2, 7); write_entry(2, 64'd0, 0, 0);
    set_count(3);
    ex[0] = pk("Zabcdefg"); ex[1] = pk("abcdefgQ"); ex[2] = pk("abcdefgh");
    ex2[0] = pk("Z0123456"); ex2[1] = pk("0123456Q"); ex2[2] = pk("01234567");
    push_exp(ex, 3);
    in_valid = 1'b1; range_dout = pk("abcdefgh");
    tick();
    check("stall_first_valid", 64'(out_valid), 64'd1);
    range_dout = pk("01234567");
    push_exp(ex2, 3);
    tick();
    out_ready = 1'b0;
    held = dout;
    check("stall_idx", 64'(out_idx), 64'd1);
    for (int r = 0; r < 3; r++) begin
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_dout", 64'(dout), 64'(held));
      check("hold_idx", 64'(out_idx), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 10 && !in_ready; t++) tick();
    check("b2b_ready", 64'(in_ready), 64'd1);
    check("b2b_last", 64'(out_last), 64'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_idx", 64'(out_idx), 64'd0);
    drain();

    // cfg writes while busy are ignored
    write_entry(0, "XY", 2, 3);
    set_count(1);
    ex[0] = pk("abcXYdef");
    out_ready = 1'b0;
    send(pk("abcdefgh"), ex, 1);
    check("busy_high", 64'(busy), 64'd1);
    cfg_wr_en = 1'b1; cfg_wr_addr = 0; cfg_word = pk("JJ"); cfg_len = 2; cfg_pos = 0;
    cfg_count_en = 1'b1; cfg_count = 3;
    tick();
    cfg_wr_en = 1'b0; cfg_count_en = 1'b0;
    out_ready = 1'b1;
    drain();
    send(pk("abcdefgh"), ex, 1);
    drain();

    // table write and accept in the same cycle
    ex[0] = pk("Kabcdefg");
    push_exp(ex, 1);
    cfg_wr_en = 1'b1; cfg_wr_addr = 0; cfg_word = pk("K"); cfg_len = 1; cfg_pos = 0;
    in_valid = 1'b1; range_dout = pk("abcdefgh");
    check("same_cycle_ready", 64'(in_ready), 64'd1);
    tick();
    cfg_wr_en = 1'b0; in_valid = 1'b0;
    drain();

    // reset mid-EMIT drops the rest and clears count
    write_entry(0, "Z", 1, 0);
    set_count(3);
    ex[0] = pk("Zabcdefg"); ex[1] = pk("abcdefgQ"); ex[2] = pk("abcdefgh");
    out_ready = 1'b0;
    send(pk("abcdefgh"), ex, 3);
    @(posedge CLK);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd0);
    check("midrst_dout", 64'(dout), 64'd0);
    sbq.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK) reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rel_ready", 64'(in_ready), 64'd1);
    ex[0] = pk("abcdefgh");
    send(pk("abcdefgh"), ex, 1);
    drain();
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
